// File: rtl/spatial_encoder_param.sv
// spatial_encoder_param: binds channel item HVs with sign-selected projections and fuses per-modality majorities.
// Optional feature macro SPATIAL_SKIP_ZERO_EN: zero features issue no read and are not counted.
module spatial_encoder_param #(
  parameter int HV_DIMENSION     = 2048,
  parameter int NUM_MODALITIES   = 3,
  parameter int CHANNELS_PER_MOD = 32,
  parameter int CHANNEL_WIDTH    = 4,
  parameter int MODE_WIDTH       = 1,
  parameter int LABEL_WIDTH      = 5,
  localparam int TOT_CH = NUM_MODALITIES * CHANNELS_PER_MOD,
  localparam int ADDR_W = (TOT_CH > 1) ? $clog2(TOT_CH) : 1
) (
  input  logic                            Clk_CI,
  input  logic                            Reset_RBI,
  input  logic                            ValidIn_SI,
  output logic                            ReadyOut_SO,
  input  logic [MODE_WIDTH-1:0]           ModeIn_SI,
  input  logic [LABEL_WIDTH-1:0]          LabelIn_DI,
  input  logic [TOT_CH*CHANNEL_WIDTH-1:0] ChannelsIn_DI,
  output logic                            MemValidOut_SO,
  input  logic                            MemReadyIn_SI,
  output logic [ADDR_W-1:0]               MemAddr_DO,
  input  logic                            MemValidIn_SI,
  input  logic [HV_DIMENSION-1:0]         IMIn_DI,
  input  logic [HV_DIMENSION-1:0]         ProjPosIn_DI,
  input  logic [HV_DIMENSION-1:0]         ProjNegIn_DI,
  output logic                            ValidOut_SO,
  input  logic                            ReadyIn_SI,
  output logic [MODE_WIDTH-1:0]           ModeOut_SO,
  output logic [LABEL_WIDTH-1:0]          LabelOut_DO,
  output logic [HV_DIMENSION-1:0]         HypervectorOut_DO
);
  localparam int CNT_W = $clog2(CHANNELS_PER_MOD + 1);
  localparam int MW = (NUM_MODALITIES > 1) ? $clog2(NUM_MODALITIES) : 1;
  localparam int KW = (CHANNELS_PER_MOD > 1) ? $clog2(CHANNELS_PER_MOD) : 1;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, ACCUM, THRESH, FUSE, OUT
  } state_e;

  state_e State_SP, State_SN;
  logic [MW-1:0] Mod_DP, Mod_DN, ModNext_D;
  logic [KW-1:0] Chan_DP, Chan_DN;
  logic [CNT_W-1:0] NumCh_DP;
  logic [MODE_WIDTH-1:0] Mode_DP;
  logic [LABEL_WIDTH-1:0] Label_DP;
  logic [TOT_CH*CHANNEL_WIDTH-1:0] Chans_DP;
  logic [HV_DIMENSION-1:0] Bound_DP, Tie_DP, Hv_DP;
  logic [CNT_W-1:0] Cnt_DP [HV_DIMENSION];
  logic [HV_DIMENSION-1:0] Bank_DP [NUM_MODALITIES];
  logic [HV_DIMENSION-1:0] ThreshHv_D, FuseHv_D;
  logic [TOT_CH-1:0] ContribIn_D, Contrib_D;
  logic [KW:0] FirstIdle_D, NextAccum_D, FirstThresh_D;
  logic [ADDR_W-1:0] Addr_D;
  logic LastMod_S, FeatNeg_S;

  // {found, index} of the first contributing channel of modality m at or after s
  function automatic logic [KW:0] firstFrom(
    input logic [TOT_CH-1:0] mask,
    input int m,
    input int s
  );
    logic [KW:0] r;
    r = '0;
    for (int j = CHANNELS_PER_MOD - 1; j >= 0; j--)
      if (j >= s && mask[m*CHANNELS_PER_MOD + j])
        r = {1'b1, KW'(j)};
    return r;
  endfunction

  always_comb begin
    for (int c = 0; c < TOT_CH; c++) begin
`ifdef SPATIAL_SKIP_ZERO_EN
      ContribIn_D[c] = |ChannelsIn_DI[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      Contrib_D[c]   = |Chans_DP[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
`else
      ContribIn_D[c] = 1'b1;
      Contrib_D[c]   = 1'b1;
`endif
    end
  end

  assign LastMod_S = (int'(Mod_DP) == NUM_MODALITIES - 1);
  assign ModNext_D = LastMod_S ? '0 : Mod_DP + 1'b1;
  assign Addr_D = ADDR_W'(int'(Mod_DP) * CHANNELS_PER_MOD + int'(Chan_DP));
  assign FeatNeg_S = Chans_DP[int'(Addr_D)*CHANNEL_WIDTH + CHANNEL_WIDTH-1];
  assign FirstIdle_D = firstFrom(ContribIn_D, 0, 0);
  assign NextAccum_D = firstFrom(Contrib_D, int'(Mod_DP), int'(Chan_DP) + 1);
  assign FirstThresh_D = firstFrom(Contrib_D, int'(ModNext_D), 0);

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      State_SP <= IDLE;
      Mod_DP   <= '0;
      Chan_DP  <= '0;
    end else begin
      State_SP <= State_SN;
      Mod_DP   <= Mod_DN;
      Chan_DP  <= Chan_DN;
    end
  end

  always_comb begin
    State_SN = State_SP;
    Mod_DN   = Mod_DP;
    Chan_DN  = Chan_DP;
    unique case (State_SP)
      IDLE:
        if (ValidIn_SI) begin
          Mod_DN   = '0;
          Chan_DN  = FirstIdle_D[KW-1:0];
          State_SN = FirstIdle_D[KW] ? REQ : THRESH;
        end
      REQ:
        if (MemReadyIn_SI) State_SN = WAIT;
      WAIT:
        if (MemValidIn_SI) State_SN = ACCUM;
      ACCUM:
        if (NextAccum_D[KW]) begin
          Chan_DN  = NextAccum_D[KW-1:0];
          State_SN = REQ;
        end else begin
          State_SN = THRESH;
        end
      THRESH:
        if (LastMod_S) begin
          State_SN = FUSE;
        end else begin
          Mod_DN   = ModNext_D;
          Chan_DN  = FirstThresh_D[KW-1:0];
          State_SN = FirstThresh_D[KW] ? REQ : THRESH;
        end
      FUSE:
        State_SN = OUT;
      OUT:
        if (ReadyIn_SI) State_SN = IDLE;
      default:
        State_SN = IDLE;
    endcase
  end

  always_comb begin
    ReadyOut_SO       = (State_SP == IDLE);
    MemValidOut_SO    = (State_SP == REQ);
    ValidOut_SO       = (State_SP == OUT);
    MemAddr_DO        = Addr_D;
    ModeOut_SO        = Mode_DP;
    LabelOut_DO       = Label_DP;
    HypervectorOut_DO = Hv_DP;
  end

  // Equal vote falls back to the tie vector (all zero when nothing contributed)
  always_comb begin
    for (int i = 0; i < HV_DIMENSION; i++) begin
      if (2 * int'(Cnt_DP[i]) > int'(NumCh_DP))
        ThreshHv_D[i] = 1'b1;
      else if (2 * int'(Cnt_DP[i]) < int'(NumCh_DP))
        ThreshHv_D[i] = 1'b0;
      else
        ThreshHv_D[i] = Tie_DP[i];
    end
  end

  always_comb begin
    int ones;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      ones = 0;
      for (int m = 0; m < NUM_MODALITIES; m++)
        ones += int'(Bank_DP[m][i]);
      if (2 * ones > NUM_MODALITIES)
        FuseHv_D[i] = 1'b1;
      else if (2 * ones < NUM_MODALITIES)
        FuseHv_D[i] = 1'b0;
      else
        FuseHv_D[i] = Bank_DP[0][i];
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      NumCh_DP <= '0;
      Mode_DP  <= '0;
      Label_DP <= '0;
      Chans_DP <= '0;
      Bound_DP <= '0;
      Tie_DP   <= '0;
      Hv_DP    <= '0;
      for (int i = 0; i < HV_DIMENSION; i++)
        Cnt_DP[i] <= '0;
      for (int m = 0; m < NUM_MODALITIES; m++)
        Bank_DP[m] <= '0;
    end else begin
      unique case (State_SP)
        IDLE:
          if (ValidIn_SI) begin
            Mode_DP  <= ModeIn_SI;
            Label_DP <= LabelIn_DI;
            Chans_DP <= ChannelsIn_DI;
          end
        WAIT:
          if (MemValidIn_SI)
            Bound_DP <= IMIn_DI ^ (FeatNeg_S ? ProjNegIn_DI : ProjPosIn_DI);
        ACCUM: begin
          for (int i = 0; i < HV_DIMENSION; i++)
            Cnt_DP[i] <= Cnt_DP[i] + CNT_W'(Bound_DP[i]);
          NumCh_DP <= NumCh_DP + 1'b1;
          if (NumCh_DP == '0) Tie_DP <= Bound_DP;
        end
        THRESH: begin
          Bank_DP[Mod_DP] <= ThreshHv_D;
          for (int i = 0; i < HV_DIMENSION; i++)
            Cnt_DP[i] <= '0;
          NumCh_DP <= '0;
          Tie_DP   <= '0;
        end
        FUSE:
          Hv_DP <= FuseHv_D;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spatial_encoder_param.sv
// tb_spatial_encoder_param: scoreboard bench, 8-bit HVs, 3x3 and 2x3 channel encoders.
// Expectations follow SPATIAL_SKIP_ZERO_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_spatial_encoder_param;
  localparam int HV = 8;
  localparam int CPM = 3;
  localparam int CW = 4;
  localparam int TC0 = 3 * CPM;
  localparam int TC1 = 2 * CPM;
  localparam int AW0 = $clog2(TC0);
  localparam int AW1 = $clog2(TC1);

`ifdef SPATIAL_SKIP_ZERO_EN
  localparam logic [7:0] T3EXP = 8'hFF;
  localparam int T3LAT = 29;
  localparam logic [7:0] ZEXP = 8'h00;
  localparam int ZLAT = 23;
  localparam int ZREQ = 0;
`else
  localparam logic [7:0] T3EXP = 8'hF7;
  localparam int T3LAT = 32;
  localparam logic [7:0] ZEXP = 8'hFF;
  localparam int ZLAT = 32;
  localparam int ZREQ = 3;
`endif
  localparam logic [35:0] T3CH = 36'h7081111FF;

  typedef struct packed {
    logic [0:0]    mode;
    logic [4:0]    label;
    logic [HV-1:0] hv;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic vIn0, rdyOut0, memV0, memR0, memVI0, vOut0, rdyIn0;
  logic [0:0] mode0, modeO0;
  logic [4:0] label0, labelO0;
  logic [TC0*CW-1:0] ch0;
  logic [AW0-1:0] addr0;
  logic [HV-1:0] im0, pp0, pn0, hvO0;
  logic [HV-1:0] imM0 [TC0];
  logic [HV-1:0] ppM0 [TC0];
  logic [HV-1:0] pnM0 [TC0];

  logic vIn1, rdyOut1, memV1, memR1, memVI1, vOut1, rdyIn1;
  logic [0:0] mode1, modeO1;
  logic [4:0] label1, labelO1;
  logic [TC1*CW-1:0] ch1;
  logic [AW1-1:0] addr1;
  logic [HV-1:0] im1, pp1, pn1, hvO1;
  logic [HV-1:0] imM1 [TC1];
  logic [HV-1:0] ppM1 [TC1];
  logic [HV-1:0] pnM1 [TC1];

  spatial_encoder_param #(
    .HV_DIMENSION(HV), .NUM_MODALITIES(3), .CHANNELS_PER_MOD(CPM),
    .CHANNEL_WIDTH(CW), .MODE_WIDTH(1), .LABEL_WIDTH(5)
  ) u0 (
    .Clk_CI(clk), .Reset_RBI(rstN),
    .ValidIn_SI(vIn0), .ReadyOut_SO(rdyOut0),
    .ModeIn_SI(mode0), .LabelIn_DI(label0), .ChannelsIn_DI(ch0),
    .MemValidOut_SO(memV0), .MemReadyIn_SI(memR0), .MemAddr_DO(addr0),
    .MemValidIn_SI(memVI0), .IMIn_DI(im0),
    .ProjPosIn_DI(pp0), .ProjNegIn_DI(pn0),
    .ValidOut_SO(vOut0), .ReadyIn_SI(rdyIn0),
    .ModeOut_SO(modeO0), .LabelOut_DO(labelO0), .HypervectorOut_DO(hvO0)
  );

  spatial_encoder_param #(
    .HV_DIMENSION(HV), .NUM_MODALITIES(2), .CHANNELS_PER_MOD(CPM),
    .CHANNEL_WIDTH(CW), .MODE_WIDTH(1), .LABEL_WIDTH(5)
  ) u1 (
    .Clk_CI(clk), .Reset_RBI(rstN),
    .ValidIn_SI(vIn1), .ReadyOut_SO(rdyOut1),
    .ModeIn_SI(mode1), .LabelIn_DI(label1), .ChannelsIn_DI(ch1),
    .MemValidOut_SO(memV1), .MemReadyIn_SI(memR1), .MemAddr_DO(addr1),
    .MemValidIn_SI(memVI1), .IMIn_DI(im1),
    .ProjPosIn_DI(pp1), .ProjNegIn_DI(pn1),
    .ValidOut_SO(vOut1), .ReadyIn_SI(rdyIn1),
    .ModeOut_SO(modeO1), .LabelOut_DO(labelO1), .HypervectorOut_DO(hvO1)
  );

  // 1-cycle read memories
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      memVI0 <= 1'b0; im0 <= '0; pp0 <= '0; pn0 <= '0;
      memVI1 <= 1'b0; im1 <= '0; pp1 <= '0; pn1 <= '0;
    end else begin
      memVI0 <= memV0 && memR0;
      if (memV0 && memR0) begin
        im0 <= imM0[addr0]; pp0 <= ppM0[addr0]; pn0 <= pnM0[addr0];
      end
      memVI1 <= memV1 && memR1;
      if (memV1 && memR1) begin
        im1 <= imM1[addr1]; pp1 <= ppM1[addr1]; pn1 <= pnM1[addr1];
      end
    end
  end

  exp_t q0[$];
  exp_t q1[$];
  int errs = 0;
  int checks = 0;
  int validCyc0 = 0;
  int acc0 = 0;
  int reqMid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  initial begin
    exp_t e;
    logic pv0, ms0, os0;
    logic [AW0-1:0] pa0;
    logic [13:0] po0;
    pv0 = 1'b0; ms0 = 1'b0; os0 = 1'b0; pa0 = '0; po0 = '0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        pv0 = 1'b0; ms0 = 1'b0; os0 = 1'b0;
      end else begin
        if (vOut0 && !pv0) validCyc0 = cyc;
        if (ms0) begin
          chk("memhold valid", 32'(memV0), 32'd1);
          chk("memhold addr", 32'(addr0), 32'(pa0));
        end
        if (os0) begin
          chk("outhold valid", 32'(vOut0), 32'd1);
          chk("outhold data", 32'({modeO0, labelO0, hvO0}), 32'(po0));
        end
        if (memV0 && memR0 && addr0 >= 3 && addr0 <= 5) reqMid++;
        if (vOut0 && rdyIn0) begin
          if (q0.size() == 0) begin
            chk("u0 unexpected output", 32'(vOut0), 32'd0);
          end else begin
            e = q0.pop_front();
            chk("u0 hv", 32'(hvO0), 32'(e.hv));
            chk("u0 mode", 32'(modeO0), 32'(e.mode));
            chk("u0 label", 32'(labelO0), 32'(e.label));
          end
        end
        if (vOut1 && rdyIn1) begin
          if (q1.size() == 0) begin
            chk("u1 unexpected output", 32'(vOut1), 32'd0);
          end else begin
            e = q1.pop_front();
            chk("u1 hv", 32'(hvO1), 32'(e.hv));
            chk("u1 mode", 32'(modeO1), 32'(e.mode));
            chk("u1 label", 32'(labelO1), 32'(e.label));
          end
        end
        pv0 = vOut0;
        ms0 = memV0 && !memR0;
        pa0 = addr0;
        os0 = vOut0 && !rdyIn0;
        po0 = {modeO0, labelO0, hvO0};
      end
    end
  end

  task automatic send0(input logic [35:0] ch, input logic [0:0] m,
                       input logic [4:0] l, input logic [7:0] hv, input bit push);
    int n = 0;
    while (!rdyOut0 && n < 300) begin @(posedge clk); #1; n++; end
    chk("u0 ready before send", 32'(rdyOut0), 32'd1);
    ch0 = ch; mode0 = m; label0 = l; vIn0 = 1'b1;
    if (push) q0.push_back({m, l, hv});
    @(posedge clk); #1;
    acc0 = cyc;
    vIn0 = 1'b0; ch0 = '1; mode0 = ~m; label0 = ~l;
  endtask

  task automatic waitDone0(input int expLat);
    int n = 0;
    while (q0.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    if (q0.size() != 0) begin
      chk("u0 output timeout", 32'(q0.size()), 32'd0);
      q0.delete();
    end else if (expLat >= 0) begin
      chk("u0 latency", validCyc0 + 1 - acc0, expLat);
    end
  endtask

  task automatic send1(input logic [23:0] ch, input logic [0:0] m,
                       input logic [4:0] l, input logic [7:0] hv);
    int n = 0;
    while (!rdyOut1 && n < 300) begin @(posedge clk); #1; n++; end
    chk("u1 ready before send", 32'(rdyOut1), 32'd1);
    ch1 = ch; mode1 = m; label1 = l; vIn1 = 1'b1;
    q1.push_back({m, l, hv});
    @(posedge clk); #1;
    vIn1 = 1'b0; ch1 = '1;
    n = 0;
    while (q1.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    if (q1.size() != 0) begin
      chk("u1 output timeout", 32'(q1.size()), 32'd0);
      q1.delete();
    end
  endtask

  task automatic memT3();
    for (int c = 0; c < TC0; c++) begin
      imM0[c] = 8'h00; ppM0[c] = 8'h00; pnM0[c] = 8'hFF;
    end
    imM0[3] = 8'h0F; imM0[4] = 8'h33; imM0[7] = 8'h55; imM0[8] = 8'hF0;
  endtask

  initial begin
    int n;
    vIn0 = 1'b0; mode0 = '0; label0 = '0; ch0 = '0; memR0 = 1'b1; rdyIn0 = 1'b1;
    vIn1 = 1'b0; mode1 = '0; label1 = '0; ch1 = '0; memR1 = 1'b1; rdyIn1 = 1'b1;
    for (int c = 0; c < TC0; c++) begin
      imM0[c] = 8'hF0; ppM0[c] = 8'h0F; pnM0[c] = 8'h00;
    end
    for (int c = 0; c < TC1; c++) begin
      imM1[c] = 8'h00; ppM1[c] = (c < 3) ? 8'hAA : 8'h55; pnM1[c] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 32'(rdyOut0), 32'd1);
    chk("reset valid", 32'(vOut0), 32'd0);
    chk("reset memvalid", 32'(memV0), 32'd0);
    chk("reset hv", 32'(hvO0), 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    send0(36'h111111111, 1'b1, 5'h13, 8'hFF, 1'b1);
    waitDone0(32);

    for (int c = 0; c < TC0; c++) begin
      imM0[c] = 8'h00; pnM0[c] = 8'h00;
      ppM0[c] = (c < 3) ? 8'h3C : (c < 6) ? 8'hFF : 8'hC3;
    end
    reqMid = 0;
    send0(36'h333000222, 1'b0, 5'h05, ZEXP, 1'b1);
    waitDone0(ZLAT);
    chk("mod1 requests", reqMid, ZREQ);

    memT3();
    send0(T3CH, 1'b0, 5'h0A, T3EXP, 1'b1);
    waitDone0(T3LAT);

    memR0 = 1'b0; rdyIn0 = 1'b0;
    send0(T3CH, 1'b1, 5'h1F, T3EXP, 1'b1);
    repeat (5) @(posedge clk);
    #1; memR0 = 1'b1;
    n = 0;
    while (!vOut0 && n < 300) begin @(posedge clk); #1; n++; end
    repeat (4) @(posedge clk);
    #1; rdyIn0 = 1'b1;
    waitDone0(-1);

    send0(T3CH, 1'b0, 5'h07, 8'h00, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rstN = 1'b0;
    #2;
    chk("abort ready", 32'(rdyOut0), 32'd1);
    chk("abort valid", 32'(vOut0), 32'd0);
    chk("abort memvalid", 32'(memV0), 32'd0);
    chk("abort addr", 32'(addr0), 32'd0);
    chk("abort hv", 32'(hvO0), 32'd0);
    chk("abort mode", 32'(modeO0), 32'd0);
    chk("abort label", 32'(labelO0), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    send0(T3CH, 1'b0, 5'h11, T3EXP, 1'b1);
    waitDone0(T3LAT);

    send1(24'h111111, 1'b1, 5'h02, 8'hAA);
    for (int c = 0; c < 3; c++) pnM1[c] = 8'hF0;
    for (int c = 3; c < TC1; c++) ppM1[c] = 8'h0F;
    send1(24'h111FFF, 1'b0, 5'h1C, 8'hF0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
